inst_rom_arbiter: RTL and testbench
===================================

Name: inst_rom_arbiter

Overview:
- Schedules the single combinational read port of the instruction ROM between two requesters.
- Requester 1 is the CPU fetch stage (IF): one word per cycle, highest priority.
- Requester 2 is the debug/boot reader (DBG): it issues burst commands, and the block sequences the beats itself.
- Sits between pc_reg/IF and inst_rom. It drives rom_ce/rom_addr and registers rom_inst back to the owning requester.

Parameters:
- ADDR_W, 32, byte-address width (matches InstAddrBus).
- DATA_W, 32, instruction word width.
- STARVE_MAX, 4, cycles a pending DBG beat may be denied before it is forced through; valid range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  IF wants a word this cycle.
- if_addr  in  ADDR_W  IF byte address.
- if_stall  out  1  combinational; 1 = IF request not granted this cycle.
- if_rvalid  out  1  if_inst valid (registered).
- if_inst  out  DATA_W  fetched word (registered).
- dbg_req  in  1  burst command request.
- dbg_addr  in  ADDR_W  burst start byte address.
- dbg_len  in  4  burst length minus 1 (1..16 words).
- dbg_ack  out  1  combinational; command accepted (dbg_req & state IDLE).
- dbg_rvalid  out  1  dbg_data valid (registered).
- dbg_data  out  DATA_W  burst beat data (registered).
- dbg_done  out  1  pulses together with the last beat's dbg_rvalid.
- rom_ce  out  1  ROM enable, combinational.
- rom_addr  out  ADDR_W  ROM byte address, combinational.
- rom_inst  in  DATA_W  ROM read data, combinational.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; beat counter, next address and starvation counter cleared.
  - All registered outputs 0. No rvalid or done appears on the cycle after reset.
  - A burst in progress is aborted.
- FSM states:
  - IDLE: if dbg_req, assert dbg_ack, latch dbg_addr&~3 and dbg_len, go to BURST.
  - BURST: go to IDLE in the cycle the beat with remaining count 0 is granted.
  - No beat is issued in the ack cycle itself.
- Per-cycle grant:
  - Candidates are IF (if_req) and DBG (state==BURST).
  - At most one grant per cycle.
  - Default priority is IF > DBG.
  - If the starvation counter equals STARVE_MAX, DBG wins and IF is stalled.
- Starvation counter:
  - Increments while DBG is pending and denied.
  - Clears on a DBG grant or on leaving BURST.
  - Saturates at STARVE_MAX.
- ROM drive:
  - rom_ce = any grant.
  - rom_addr = if_addr on an IF grant, the burst next-address on a DBG grant, otherwise 0.
  - if_addr is passed unaligned; the ROM ignores bits [1:0].
- if_stall = if_req & ~IF grant.
- Latency: exactly 1 cycle.
  - rom_inst is captured at the grant-cycle posedge into the owner's data register, and the owner's rvalid is set for one cycle.
  - Non-owner rvalid is 0; its data register holds its previous value.
- DBG beat:
  - Next-address += 4, wrapping modulo 2^ADDR_W.
  - Remaining count decrements.
  - The last beat sets dbg_done together with dbg_rvalid.
- A dbg_req during BURST is ignored (dbg_ack=0). It must be held until acked.
- if_req without contention: granted every cycle, giving back-to-back if_rvalid.
- If rom_ce=0, rom_inst is ignored.

Optional Feature:
- Macro: ROM_ARB_RR_EN.
- Defined: on contention, grant alternates starting with IF after reset. A one-bit last-winner register picks the loser of the previous contended cycle. Uncontended grants do not update the register. The starvation counter and STARVE_MAX have no effect.
- Undefined: fixed IF > DBG priority with the starvation override described above.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with no requests -> rom_ce=0, all rvalid/done/stall 0, if_inst=dbg_data=0.
- IF streaming: if_req=1, if_addr=0,4,8 on consecutive cycles with ROM words W0..W2 -> if_stall=0 throughout; if_rvalid=1 on cycles 2-4 with if_inst=W0,W1,W2.
- Burst alone: dbg_req with dbg_addr=0x102, dbg_len=3 -> dbg_ack next-edge state; rom_addr=0x100,0x104,0x108,0x10C on 4 consecutive cycles; 4 dbg_rvalid; dbg_done only with the 4th.
- Starvation (STARVE_MAX=4, macro off): if_req held high during a 2-beat burst -> DBG denied 4 cycles; 5th cycle DBG granted with if_stall=1; counter resets; IF is stalled again only after 4 further denied cycles.
- Round-robin (ROM_ARB_RR_EN): if_req held high plus burst dbg_len=2 -> grants alternate IF, DBG, IF, DBG, IF, DBG; burst finishes in 6 cycles.
- Reset mid-burst: rst=0 after beat 1 of dbg_len=7 -> no further dbg_rvalid and no dbg_done; after release, dbg_ack available in IDLE.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the single combinational instruction-ROM read port
// between the IF fetch stage (one word per cycle, default highest priority)
// and a debug/boot burst reader whose beats are sequenced here.
// Read data is registered back to the owning requester one cycle after grant.
// Optional build macro ROM_ARB_RR_EN: contended cycles alternate IF/DBG
// (IF first after reset) instead of fixed IF priority with starvation override.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_inst,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [3:0]        dbg_len,
  output logic              dbg_ack,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;   // address of the next burst beat
  logic [3:0]        cnt_reg, cnt_next;     // beats remaining after the next one
  logic              grant_if, grant_dbg, dbg_pend;

  logic              if_rvalid_reg, dbg_rvalid_reg, dbg_done_reg;
  logic [DATA_W-1:0] if_inst_reg, dbg_data_reg;

`ifdef ROM_ARB_RR_EN
  logic last_dbg_reg, last_dbg_next;        // 1 = DBG won the last contended cycle
  logic contended;

  // Grant selection: alternate on contention, otherwise the sole requester wins
  always_comb begin
    dbg_pend      = (state_reg == BURST);
    contended     = if_req & dbg_pend;
    grant_dbg     = contended ? ~last_dbg_reg : dbg_pend;
    grant_if      = if_req & ~grant_dbg;
    last_dbg_next = contended ? grant_dbg : last_dbg_reg;
  end

  // Last-winner register; reset value makes IF win the first contention
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_dbg_reg <= 1'b1;
    end else begin
      last_dbg_reg <= last_dbg_next;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_reg, starve_next;

  // Grant selection: IF first unless a pending DBG beat has been denied too long
  always_comb begin
    dbg_pend  = (state_reg == BURST);
    grant_dbg = dbg_pend & (~if_req | (starve_reg == STARVE_LIM));
    grant_if  = if_req & ~grant_dbg;
  end

  // Starvation count: grows while a beat waits, clears on grant or outside a burst
  always_comb begin
    starve_next = starve_reg;
    if (!dbg_pend || grant_dbg) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_LIM) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end
`endif

  // Burst sequencer: accept commands in IDLE, step address/count on each DBG grant
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    dbg_ack    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dbg_req) begin
          dbg_ack    = 1'b1;
          addr_next  = {dbg_addr[ADDR_W-1:2], 2'b00};
          cnt_next   = dbg_len;
          state_next = BURST;
        end
      end
      BURST: begin
        if (grant_dbg) begin
          addr_next = addr_reg + ADDR_W'(4);
          cnt_next  = cnt_reg - 4'd1;
          if (cnt_reg == 4'd0) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ROM port drive and IF stall, all combinational from this cycle's grant
  always_comb begin
    rom_ce   = grant_if | grant_dbg;
    rom_addr = '0;
    if (grant_if) begin
      rom_addr = if_addr;
    end else if (grant_dbg) begin
      rom_addr = addr_reg;
    end
    if_stall = if_req & ~grant_if;
  end

  // FSM and burst bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Return path: capture ROM data into the owner's register, one-cycle valid pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rvalid_reg  <= 1'b0;
      if_inst_reg    <= '0;
      dbg_rvalid_reg <= 1'b0;
      dbg_data_reg   <= '0;
      dbg_done_reg   <= 1'b0;
    end else begin
      if_rvalid_reg  <= grant_if;
      dbg_rvalid_reg <= grant_dbg;
      dbg_done_reg   <= grant_dbg & (cnt_reg == 4'd0);
      if (grant_if) begin
        if_inst_reg <= rom_inst;
      end
      if (grant_dbg) begin
        dbg_data_reg <= rom_inst;
      end
    end
  end

  assign if_rvalid  = if_rvalid_reg;
  assign if_inst    = if_inst_reg;
  assign dbg_rvalid = dbg_rvalid_reg;
  assign dbg_data   = dbg_data_reg;
  assign dbg_done   = dbg_done_reg;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Testbench for inst_rom_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based model.
module tb_inst_rom_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_stall, if_rvalid;
  logic [31:0] if_inst;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic [3:0]  dbg_len;
  logic        dbg_ack, dbg_rvalid, dbg_done;
  logic [31:0] dbg_data;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
  logic [31:0] noise;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM content: word index in the low half, recognizable tag in the high half
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  // Unenabled reads return junk that must never be captured
  assign rom_inst = rom_ce ? rom_word(rom_addr) : noise;

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_inst(if_inst),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_data(dbg_data),
    .dbg_done(dbg_done),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [31:0] m_q[$];           // byte addresses of burst beats still to be read
  int          m_denied = 0;     // consecutive cycles the head beat was refused
  bit          m_last_dbg = 1'b1;
  logic        e_if_rvalid = 0, e_dbg_rvalid = 0, e_dbg_done = 0;
  logic [31:0] e_if_inst = 0, e_dbg_data = 0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit          burst, gd, gi, ack, contended;
        logic [31:0] exp_addr;
        burst     = (m_q.size() > 0);
        ack       = dbg_req && !burst;
        contended = if_req && burst;
`ifdef ROM_ARB_RR_EN
        gd = contended ? !m_last_dbg : burst;
`else
        gd = burst && (!if_req || m_denied == STARVE_MAX);
`endif
        gi       = if_req && !gd;
        exp_addr = gi ? if_addr : (gd ? m_q[0] : 32'h0);

        check("if_stall",   {31'b0, if_stall},   {31'b0, if_req && !gi});
        check("dbg_ack",    {31'b0, dbg_ack},    {31'b0, ack});
        check("rom_ce",     {31'b0, rom_ce},     {31'b0, gi || gd});
        check("rom_addr",   rom_addr,            exp_addr);
        check("if_rvalid",  {31'b0, if_rvalid},  {31'b0, e_if_rvalid});
        check("if_inst",    if_inst,             e_if_inst);
        check("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, e_dbg_rvalid});
        check("dbg_data",   dbg_data,            e_dbg_data);
        check("dbg_done",   {31'b0, dbg_done},   {31'b0, e_dbg_done});

        // advance model to the state following the coming posedge
        if (!rst) begin
          m_q.delete();
          m_denied     = 0;
          m_last_dbg   = 1'b1;
          e_if_rvalid  = 0; e_if_inst  = 0;
          e_dbg_rvalid = 0; e_dbg_data = 0; e_dbg_done = 0;
        end else begin
          e_if_rvalid  = gi;
          e_dbg_rvalid = gd;
          e_dbg_done   = 0;
          if (gi) e_if_inst = rom_word(if_addr);
          if (gd) begin
            e_dbg_data = rom_word(m_q[0]);
            e_dbg_done = (m_q.size() == 1);
            void'(m_q.pop_front());
            m_denied = 0;
          end else if (burst) begin
            m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
          end
          if (contended) m_last_dbg = gd;
          if (ack) begin
            for (int k = 0; k <= int'(dbg_len); k++)
              m_q.push_back({dbg_addr[31:2], 2'b00} + 32'(4 * k));
          end
        end
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_req = 0; if_addr = 0; dbg_req = 0; dbg_addr = 0; dbg_len = 0;
    noise = 32'hDEAD_BEEF;

    // reset then idle
    tick(); tick();
    rst = 1'b1;
    tick(); #2;
    check("idle_rom_ce",   {31'b0, rom_ce},   32'h0);
    check("idle_if_stall", {31'b0, if_stall}, 32'h0);
    check("idle_rvalid",   {30'b0, if_rvalid, dbg_rvalid}, 32'h0);
    check("idle_done",     {31'b0, dbg_done}, 32'h0);
    check("idle_if_inst",  if_inst,  32'h0);
    check("idle_dbg_data", dbg_data, 32'h0);

    // IF streaming
    tick(); if_req = 1; if_addr = 32'h0; #2;
    check("ifs_stall0", {31'b0, if_stall}, 32'h0);
    check("ifs_addr0",  rom_addr, 32'h0);
    tick(); if_addr = 32'h4; #2;
    check("ifs_rv1",   {31'b0, if_rvalid}, 32'h1);
    check("ifs_inst1", if_inst, 32'hC0DE_0000);
    tick(); if_addr = 32'h8; #2;
    check("ifs_inst2", if_inst, 32'hC0DE_0001);
    tick(); if_req = 0; #2;
    check("ifs_inst3", if_inst, 32'hC0DE_0002);
    check("ifs_rv3",   {31'b0, if_rvalid}, 32'h1);
    tick(); #2;
    check("ifs_rv_end", {31'b0, if_rvalid}, 32'h0);

    // burst alone, unaligned start
    tick(); dbg_req = 1; dbg_addr = 32'h102; dbg_len = 4'd3; #2;
    check("bst_ack",    {31'b0, dbg_ack}, 32'h1);
    check("bst_ce_ack", {31'b0, rom_ce},  32'h0);
    tick(); dbg_req = 0; #2;
    check("bst_addr0", rom_addr, 32'h100);
    for (int k = 1; k < 4; k++) begin
      tick(); #2;
      check("bst_addr", rom_addr, 32'h100 + 32'(4 * k));
      check("bst_rv",   {31'b0, dbg_rvalid}, 32'h1);
      check("bst_nodone", {31'b0, dbg_done}, 32'h0);
    end
    tick(); #2;
    check("bst_done", {31'b0, dbg_done}, 32'h1);
    check("bst_data", dbg_data, 32'hC0DE_0043);
    tick(); #2;
    check("bst_rv_end", {31'b0, dbg_rvalid}, 32'h0);

`ifdef ROM_ARB_RR_EN
    // round-robin: IF, DBG alternate on contention
    tick(); if_req = 1; if_addr = 32'h40; dbg_req = 1; dbg_addr = 32'h200; dbg_len = 4'd2; #2;
    check("rr_ack", {31'b0, dbg_ack}, 32'h1);
    for (int c = 1; c <= 6; c++) begin
      tick(); dbg_req = 0; #2;
      check("rr_stall", {31'b0, if_stall}, (c % 2 == 0) ? 32'h1 : 32'h0);
    end
    tick(); if_req = 0; #2;
    check("rr_done", {31'b0, dbg_done}, 32'h1);
    check("rr_data", dbg_data, 32'hC0DE_0082);
`else
    // starvation override during a 2-beat burst with IF held high
    tick(); if_req = 1; if_addr = 32'h40; dbg_req = 1; dbg_addr = 32'h200; dbg_len = 4'd1; #2;
    check("stv_ack",   {31'b0, dbg_ack},  32'h1);
    check("stv_stall", {31'b0, if_stall}, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      tick(); dbg_req = 0; #2;
      check("stv_stall", {31'b0, if_stall}, (c == 5 || c == 10) ? 32'h1 : 32'h0);
      if (c == 5)  check("stv_addr5",  rom_addr, 32'h200);
      if (c == 10) check("stv_addr10", rom_addr, 32'h204);
    end
    tick(); if_req = 0; #2;
    check("stv_done", {31'b0, dbg_done}, 32'h1);
    check("stv_data", dbg_data, 32'hC0DE_0081);
`endif

    // reset in the middle of a long burst
    tick(); if_req = 0; dbg_req = 1; dbg_addr = 32'h300; dbg_len = 4'd7; #2;
    check("rmb_ack", {31'b0, dbg_ack}, 32'h1);
    tick(); dbg_req = 0; #2;
    check("rmb_addr0", rom_addr, 32'h300);
    tick(); #2;
    check("rmb_addr1", rom_addr, 32'h304);
    check("rmb_rv0", {31'b0, dbg_rvalid}, 32'h1);
    tick(); rst = 0;
    tick(); rst = 1; #2;
    check("rmb_rv_cut", {31'b0, dbg_rvalid}, 32'h0);
    check("rmb_ce_cut", {31'b0, rom_ce},     32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      check("rmb_quiet", {30'b0, dbg_rvalid, dbg_done}, 32'h0);
    end
    tick(); dbg_req = 1; dbg_addr = 32'h10; dbg_len = 4'd0; #2;
    check("rmb_reack", {31'b0, dbg_ack}, 32'h1);
    tick(); dbg_req = 0;

    // randomized traffic, including address wrap and occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst      = ($urandom_range(0, 299) != 0);
      if_req   = ($urandom_range(0, 9) < 6);
      if_addr  = $urandom();
      dbg_req  = ($urandom_range(0, 9) < 3);
      dbg_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      dbg_len  = 4'($urandom());
      noise    = $urandom();
    end
    tick();
    rst = 1; if_req = 0; dbg_req = 0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
